// File: rtl/net_l2dr_xbar.sv
// net_l2dr_xbar: N-port crossbar stage between the L2 pipes and one directory port.
// Requests are buffered per port, arbitrated onto a single registered directory
// output and tagged with their source port. Directory responses are steered back
// to the L2 pipe named by dr_rsp_dst through one output register per port.
module net_l2dr_xbar #(
    parameter int NPORTS   = 4,
    parameter int DW       = 64,
    parameter int DEPTH    = 2,
    parameter int ARB_MODE = 0,
    localparam int SW      = $clog2(NPORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    l2_req_valid,
    output logic [NPORTS-1:0]    l2_req_retry,
    input  logic [NPORTS*DW-1:0] l2_req,
    output logic                 dr_req_valid,
    input  logic                 dr_req_retry,
    output logic [DW-1:0]        dr_req,
    output logic [SW-1:0]        dr_req_src,
    input  logic                 dr_rsp_valid,
    output logic                 dr_rsp_retry,
    input  logic [DW-1:0]        dr_rsp,
    input  logic [SW-1:0]        dr_rsp_dst,
    output logic [NPORTS-1:0]    l2_rsp_valid,
    input  logic [NPORTS-1:0]    l2_rsp_retry,
    output logic [NPORTS*DW-1:0] l2_rsp,
    output logic [7:0]           err_cnt
);
    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Request side: per-port FIFOs
    // ------------------------------------------------------------------
    logic [NPORTS-1:0] fifo_full;
    logic [NPORTS-1:0] fifo_empty;
    logic [NPORTS-1:0] fifo_push;
    logic [NPORTS-1:0] fifo_pop;
    logic [DW-1:0]     fifo_head [NPORTS];

    logic              can_load;
    logic              grant_valid;
    logic [SW-1:0]     grant_idx;
    logic [DW-1:0]     grant_data;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_fifo
            logic [DW-1:0] mem_q [DEPTH];
            logic [AW:0]   wr_ptr_q;
            logic [AW:0]   rd_ptr_q;

            // Extra pointer bit separates full (MSB differs) from empty (equal)
            assign fifo_full[gi]  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
            assign fifo_empty[gi] = (wr_ptr_q == rd_ptr_q);
            assign fifo_push[gi]  = l2_req_valid[gi] & ~fifo_full[gi];
            assign fifo_pop[gi]   = can_load & grant_valid & (grant_idx == SW'(gi));
            assign fifo_head[gi]  = mem_q[rd_ptr_q[AW-1:0]];

            // Payload storage; contents are don't-care until the pointers cover them
            always_ff @(posedge clk) begin
                if (fifo_push[gi]) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= l2_req[gi*DW +: DW];
                end
            end

            // Read/write pointers; reset empties the FIFO and drops buffered beats
            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (fifo_push[gi]) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                    if (fifo_pop[gi])  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                end
            end
        end
    endgenerate

    // Retry depends only on registered pointers, never on l2_req_valid
    assign l2_req_retry = fifo_full;

    // ------------------------------------------------------------------
    // Arbiter and directory output register
    // ------------------------------------------------------------------
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [SW-1:0] out_src_q,   out_src_d;
    logic [SW-1:0] last_grant_q, last_grant_d;

    // Output register accepts a new head when empty or draining this cycle
    assign can_load = ~out_valid_q | ~dr_req_retry;

    // Pick one non-empty FIFO: lowest index, or rotating from last_grant+1
    always_comb begin
        int p;
        grant_valid = 1'b0;
        grant_idx   = '0;
        p           = 0;
        if (ARB_MODE == 1) begin
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (!fifo_empty[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SW'(i);
                end
            end
        end else begin
            // Walk offsets downward so the smallest offset wins
            for (int off = NPORTS; off >= 1; off--) begin
                p = int'(last_grant_q) + off;
                if (p >= NPORTS) p = p - NPORTS;
                if (!fifo_empty[p]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SW'(p);
                end
            end
        end
    end

    // Head-of-line mux for the granted port
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_idx == SW'(i)) grant_data = fifo_head[i];
        end
    end

    // Next state of the output register and round-robin pointer
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (can_load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d   = grant_data;
                out_src_d    = grant_idx;
                last_grant_d = grant_idx;
            end
        end
    end

    // Output register state; last_grant resets so port 0 is searched first
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SW'(NPORTS - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign dr_req_valid = out_valid_q;
    assign dr_req       = out_data_q;
    assign dr_req_src   = out_src_q;

    // ------------------------------------------------------------------
    // Response side: per-port output registers
    // ------------------------------------------------------------------
    logic [NPORTS-1:0] dst_hit;
    logic              rsp_dst_ok;
    logic              rsp_accept;
    logic [7:0]        err_cnt_q, err_cnt_d;

    // A destination outside 0..NPORTS-1 hits no port and counts as misrouted
    assign rsp_dst_ok   = |dst_hit;
    assign dr_rsp_retry = |(dst_hit & l2_rsp_valid & l2_rsp_retry);
    assign rsp_accept   = dr_rsp_valid & ~dr_rsp_retry;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rsp
            logic          valid_q;
            logic [DW-1:0] data_q;

            assign dst_hit[gi]              = (dr_rsp_dst == SW'(gi));
            assign l2_rsp_valid[gi]         = valid_q;
            assign l2_rsp[gi*DW +: DW]      = data_q;

            // Load on a routed beat; a reload wins over the drain in the same cycle
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (rsp_accept & dst_hit[gi]) begin
                    valid_q <= 1'b1;
                    data_q  <= dr_rsp;
                end else if (valid_q & ~l2_rsp_retry[gi]) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    // Saturating misroute counter
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rsp_accept & ~rsp_dst_ok & (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Misroute counter register
    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;

endmodule
